// File: rtl/cache_controller.sv
`default_nettype none
// ============================================================================
// Module      : cache_controller
// Description : 2-way set-associative, write-through, no-write-allocate data
//               cache sitting between the MEM stage and an SRAM controller.
//               64 sets, two 32-bit words per line, one LRU bit per set.
//               Read hits are served combinationally in IDLE; misses fetch the
//               two line words with two SRAM reads; stores always go to SRAM
//               and update the cached word only on a hit.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               address, wdata      - MEM stage byte address / store data
//               mem_r_en, mem_w_en  - load / store request (store has priority)
//               rdata, ready        - load data, 0 on ready freezes pipeline
//               sram_address, sram_wdata, sram_read_en, sram_write_en
//                                   - request side of the SRAM controller
//               sram_rdata, sram_ready
//                                   - SRAM read data and completion strobe
// Revision    : 1.0 - initial release
// ============================================================================
module cache_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  output logic        sram_read_en,
  output logic        sram_write_en,
  input  logic [31:0] sram_rdata,
  input  logic        sram_ready
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RD_W0 = 2'd1;
  localparam logic [1:0] S_RD_W1 = 2'd2;
  localparam logic [1:0] S_WR    = 2'd3;

  localparam int SETS = 64;

  logic [1:0]      state_q, state_d;
  logic [31:0]     data0_q [0:SETS-1][0:1];
  logic [31:0]     data1_q [0:SETS-1][0:1];
  logic [9:0]      tag0_q  [0:SETS-1];
  logic [9:0]      tag1_q  [0:SETS-1];
  logic [SETS-1:0] valid0_q, valid1_q, lru_q;
  logic [31:0]     word0_q;

  // Offset into the data region, word-granular: bit 0 here is byte-offset
  // bit 2. The data region base (1024) is a multiple of 8, so the word
  // select and line alignment are unaffected by the subtraction.
  logic [16:0] off_w;
  logic        word_sel_w;
  logic [5:0]  index_w;
  logic [9:0]  tag_w;

  assign off_w      = address[18:2] - 17'd256;
  assign word_sel_w = off_w[0];
  assign index_w    = off_w[6:1];
  assign tag_w      = off_w[16:7];

  logic        hit0_w, hit1_w, hit_w;
  logic [31:0] hit_word_w;
  logic        victim_w;

  assign hit0_w     = valid0_q[index_w] && (tag0_q[index_w] == tag_w);
  assign hit1_w     = valid1_q[index_w] && (tag1_q[index_w] == tag_w);
  assign hit_w      = hit0_w | hit1_w;
  assign hit_word_w = hit1_w ? data1_q[index_w][word_sel_w]
                             : data0_q[index_w][word_sel_w];

  // Fill an empty way first; only when both are valid does LRU decide.
  assign victim_w = !valid0_q[index_w] ? 1'b0 :
                    !valid1_q[index_w] ? 1'b1 : lru_q[index_w];

  logic rd_hit_w, wr_hit_w, capture_w, fill_w;

  always_comb begin
    state_d       = state_q;
    ready         = 1'b0;
    rdata         = 32'd0;
    sram_address  = 32'd0;
    sram_wdata    = 32'd0;
    sram_read_en  = 1'b0;
    sram_write_en = 1'b0;
    rd_hit_w      = 1'b0;
    wr_hit_w      = 1'b0;
    capture_w     = 1'b0;
    fill_w        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_w_en) begin
          state_d = S_WR;
        end else if (mem_r_en) begin
          if (hit_w) begin
            ready    = 1'b1;
            rdata    = hit_word_w;
            rd_hit_w = 1'b1;
          end else begin
            state_d = S_RD_W0;
          end
        end else begin
          ready = 1'b1;
        end
      end
      S_RD_W0: begin
        sram_read_en = 1'b1;
        sram_address = {address[31:3], 3'b000};
        if (sram_ready) begin
          capture_w = 1'b1;
          state_d   = S_RD_W1;
        end
      end
      S_RD_W1: begin
        sram_read_en = 1'b1;
        sram_address = {address[31:3], 3'b100};
        // The line is written at this edge; the held request then hits
        // from IDLE on the following cycle.
        if (sram_ready) begin
          fill_w  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WR: begin
        sram_write_en = 1'b1;
        sram_address  = address;
        sram_wdata    = wdata;
        if (sram_ready) begin
          ready    = 1'b1;
          wr_hit_w = hit_w;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state: FSM, valid bits and LRU bits are cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      valid0_q <= '0;
      valid1_q <= '0;
      lru_q    <= '0;
    end else begin
      state_q <= state_d;
      if (fill_w) begin
        if (victim_w) begin
          valid1_q[index_w] <= 1'b1;
        end else begin
          valid0_q[index_w] <= 1'b1;
        end
        lru_q[index_w] <= ~victim_w;
      end
      // LRU points at the way that was not just used.
      if (rd_hit_w || wr_hit_w) begin
        lru_q[index_w] <= ~hit1_w;
      end
    end
  end

  // Data and tag storage; no reset needed since valid bits gate every use.
  // Updates are suppressed under reset so an aborted miss leaves no trace.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (capture_w) begin
        word0_q <= sram_rdata;
      end
      if (fill_w) begin
        if (victim_w) begin
          data1_q[index_w][0] <= word0_q;
          data1_q[index_w][1] <= sram_rdata;
          tag1_q[index_w]     <= tag_w;
        end else begin
          data0_q[index_w][0] <= word0_q;
          data0_q[index_w][1] <= sram_rdata;
          tag0_q[index_w]     <= tag_w;
        end
      end
      if (wr_hit_w) begin
        if (hit1_w) begin
          data1_q[index_w][word_sel_w] <= wdata;
        end else begin
          data0_q[index_w][word_sel_w] <= wdata;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_controller
// Description : Self-checking bench for cache_controller. An SRAM model with
//               random latency answers requests; a recency-list cache model
//               and a reference memory predict hit/miss and load data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] address = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        mem_r_en = 1'b0;
  logic        mem_w_en = 1'b0;
  logic [31:0] rdata;
  logic        ready;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic        sram_read_en;
  logic        sram_write_en;
  logic [31:0] sram_rdata;
  logic        sram_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_controller dut (
    .clk          (clk),
    .rst          (rst),
    .address      (address),
    .wdata        (wdata),
    .mem_r_en     (mem_r_en),
    .mem_w_en     (mem_w_en),
    .rdata        (rdata),
    .ready        (ready),
    .sram_address (sram_address),
    .sram_wdata   (sram_wdata),
    .sram_read_en (sram_read_en),
    .sram_write_en(sram_write_en),
    .sram_rdata   (sram_rdata),
    .sram_ready   (sram_ready)
  );

  // ---------------- SRAM model ----------------
  logic [31:0] sram_mem [0:4095];
  logic [31:0] ref_mem  [0:4095];
  int          lat_cnt = 0;
  int          lat = 1;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] rd_addr_q [$];
  logic [31:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  bit          both_seen = 1'b0;

  assign sram_ready = (sram_read_en || sram_write_en) ? (lat_cnt >= lat) : 1'b1;
  assign sram_rdata = sram_mem[sram_address[13:2]];

  always @(posedge clk) begin
    if (sram_read_en && sram_write_en) both_seen <= 1'b1;
    if (rst) begin
      lat_cnt <= 0;
    end else if ((sram_read_en || sram_write_en) && sram_ready) begin
      lat_cnt <= 0;
      lat     <= int'($urandom_range(1, 3));
      if (sram_read_en) begin
        rd_cnt <= rd_cnt + 1;
        rd_addr_q.push_back(sram_address);
      end
      if (sram_write_en) begin
        wr_cnt <= wr_cnt + 1;
        wr_addr_q.push_back(sram_address);
        wr_data_q.push_back(sram_wdata);
        sram_mem[sram_address[13:2]] <= sram_wdata;
      end
    end else if (sram_read_en || sram_write_en) begin
      lat_cnt <= lat_cnt + 1;
    end else begin
      lat_cnt <= 0;
    end
  end

  // ---------------- Cache model: per-set recency list, MRU first ----------------
  int m_tag [64][2];
  int m_cnt [64];

  function automatic int set_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return int'(off[8:3]);
  endfunction

  function automatic int tag_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return int'(off[18:9]);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 64; s++) m_cnt[s] = 0;
  endtask

  function automatic bit model_hit(input logic [31:0] a);
    int s, t;
    s = set_of(a);
    t = tag_of(a);
    for (int i = 0; i < m_cnt[s]; i++) if (m_tag[s][i] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_touch(input logic [31:0] a);
    int s, t;
    s = set_of(a);
    t = tag_of(a);
    if (m_cnt[s] >= 1 && m_tag[s][0] == t) return;
    if (m_cnt[s] == 2 && m_tag[s][1] == t) begin
      m_tag[s][1] = m_tag[s][0];
      m_tag[s][0] = t;
      return;
    end
    m_tag[s][1] = m_tag[s][0];
    m_tag[s][0] = t;
    if (m_cnt[s] < 2) m_cnt[s]++;
  endtask

  // A load always brings the line in (or refreshes it).
  task automatic model_read(input logic [31:0] a, output bit hit);
    hit = model_hit(a);
    model_touch(a);
  endtask

  // Stores update memory; only a hit counts as a use of the line.
  task automatic model_write(input logic [31:0] a, input logic [31:0] d, output bit hit);
    hit = model_hit(a);
    if (hit) model_touch(a);
    ref_mem[a[13:2]] = d;
  endtask

  // ---------------- Drivers (called at posedge + 1) ----------------
  task automatic do_read(input logic [31:0] a, output int cyc, output logic [31:0] data,
                         output int nrd, output int nwr,
                         output logic [31:0] a0, output logic [31:0] a1, output bit to);
    int r0, w0;
    bit done;
    r0 = rd_cnt; w0 = wr_cnt; cyc = 0; to = 1'b0; done = 1'b0;
    address = a; mem_r_en = 1'b1; mem_w_en = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (ready) done = 1'b1;
      else begin
        cyc++;
        if (cyc > 100) begin to = 1'b1; done = 1'b1; end
      end
    end
    data = rdata;
    @(posedge clk); #1;
    mem_r_en = 1'b0;
    nrd = rd_cnt - r0;
    nwr = wr_cnt - w0;
    a0 = (nrd >= 1) ? rd_addr_q[r0] : 32'd0;
    a1 = (nrd >= 2) ? rd_addr_q[r0+1] : 32'd0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input bit with_read,
                          output bit first_ready, output logic [31:0] first_rdata,
                          output int nrd, output int nwr,
                          output logic [31:0] wa, output logic [31:0] wd, output bit to);
    int r0, w0, cyc;
    bit done;
    r0 = rd_cnt; w0 = wr_cnt; cyc = 0; to = 1'b0; done = 1'b0;
    first_ready = 1'b0; first_rdata = 32'd0;
    address = a; wdata = d; mem_w_en = 1'b1; mem_r_en = with_read;
    while (!done) begin
      @(negedge clk);
      if (cyc == 0) begin first_ready = ready; first_rdata = rdata; end
      if (ready && cyc > 0) done = 1'b1;
      else begin
        cyc++;
        if (cyc > 100) begin to = 1'b1; done = 1'b1; end
      end
    end
    @(posedge clk); #1;
    mem_w_en = 1'b0; mem_r_en = 1'b0;
    nrd = rd_cnt - r0;
    nwr = wr_cnt - w0;
    wa = (nwr >= 1) ? wr_addr_q[w0] : 32'd0;
    wd = (nwr >= 1) ? wr_data_q[w0] : 32'd0;
  endtask

  // ---------------- Tests ----------------
  task automatic test_reset();
    rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    checks++; if (sram_read_en !== 1'b0 || sram_write_en !== 1'b0) begin
      errors++; $display("FAIL reset_enables got=%b%b exp=00", sram_read_en, sram_write_en); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    checks++; if (ready !== 1'b1 || sram_read_en !== 1'b0 || sram_write_en !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle got ready=%b en=%b%b exp ready=1 en=00",
                         ready, sram_read_en, sram_write_en); end
    @(posedge clk); #1;
  endtask

  task automatic test_cold_read();
    int cyc, nrd, nwr; logic [31:0] d, a0, a1; bit to, h;
    model_read(32'd1032, h);
    do_read(32'd1032, cyc, d, nrd, nwr, a0, a1, to);
    checks++; if (to || cyc == 0) begin errors++; $display("FAIL cold_stall cycles=%0d timeout=%b exp stall", cyc, to); end
    checks++; if (nrd != 2 || a0 !== 32'd1032 || a1 !== 32'd1036) begin
      errors++; $display("FAIL cold_sram_reads n=%0d a0=%0d a1=%0d exp n=2 1032 1036", nrd, a0, a1); end
    checks++; if (d !== ref_mem[258]) begin errors++; $display("FAIL cold_rdata got=%h exp=%h", d, ref_mem[258]); end
  endtask

  task automatic test_reread();
    int cyc, nrd, nwr; logic [31:0] d, a0, a1; bit to, h;
    model_read(32'd1036, h);
    do_read(32'd1036, cyc, d, nrd, nwr, a0, a1, to);
    checks++; if (cyc != 0 || nrd != 0 || nwr != 0) begin
      errors++; $display("FAIL reread_hit cycles=%0d rd=%0d wr=%0d exp 0 0 0", cyc, nrd, nwr); end
    checks++; if (d !== ref_mem[259]) begin errors++; $display("FAIL reread_rdata got=%h exp=%h", d, ref_mem[259]); end
  endtask

  task automatic test_lru();
    logic [31:0] addrs [6];
    bit exp_hit [6];
    int cyc, nrd, nwr; logic [31:0] d, a0, a1; bit to, h;
    addrs   = '{32'd1024, 32'd1536, 32'd2048, 32'd1024, 32'd2048, 32'd1536};
    exp_hit = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      model_read(addrs[i], h);
      do_read(addrs[i], cyc, d, nrd, nwr, a0, a1, to);
      checks++; if (to || (exp_hit[i] ? nrd != 0 : nrd != 2)) begin
        errors++; $display("FAIL lru_step%0d addr=%0d sram_reads=%0d exp_hit=%b", i, addrs[i], nrd, exp_hit[i]); end
      checks++; if (d !== ref_mem[addrs[i][13:2]]) begin
        errors++; $display("FAIL lru_rdata%0d got=%h exp=%h", i, d, ref_mem[addrs[i][13:2]]); end
    end
  endtask

  task automatic test_write_hit();
    bit fr, to, h; logic [31:0] frd, wa, wd, d, a0, a1; int nrd, nwr, cyc;
    model_write(32'd1032, 32'hDEADBEEF, h);
    do_write(32'd1032, 32'hDEADBEEF, 1'b0, fr, frd, nrd, nwr, wa, wd, to);
    checks++; if (to || nwr != 1 || nrd != 0 || wa !== 32'd1032 || wd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_hit_sram wr=%0d rd=%0d addr=%0d data=%h exp 1 0 1032 deadbeef", nwr, nrd, wa, wd); end
    model_read(32'd1032, h);
    do_read(32'd1032, cyc, d, nrd, nwr, a0, a1, to);
    checks++; if (cyc != 0 || nrd != 0 || nwr != 0 || d !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_hit_readback got=%h cycles=%0d rd=%0d wr=%0d exp deadbeef 0 0 0", d, cyc, nrd, nwr); end
  endtask

  task automatic test_write_miss();
    bit fr, to, h; logic [31:0] frd, wa, wd, d, a0, a1; int nrd, nwr, cyc;
    model_write(32'd4096, 32'h1234_5678, h);
    do_write(32'd4096, 32'h1234_5678, 1'b0, fr, frd, nrd, nwr, wa, wd, to);
    checks++; if (to || nwr != 1 || nrd != 0 || wa !== 32'd4096) begin
      errors++; $display("FAIL wr_miss_sram wr=%0d rd=%0d addr=%0d exp 1 0 4096", nwr, nrd, wa); end
    model_read(32'd4096, h);
    do_read(32'd4096, cyc, d, nrd, nwr, a0, a1, to);
    checks++; if (nrd != 2 || d !== 32'h1234_5678) begin
      errors++; $display("FAIL wr_miss_readback rd=%0d got=%h exp 2 12345678", nrd, d); end
  endtask

  task automatic test_priority();
    bit fr, to, h; logic [31:0] frd, wa, wd, d, a0, a1; int nrd, nwr, cyc;
    model_write(32'd1036, 32'hCAFE_0001, h);
    do_write(32'd1036, 32'hCAFE_0001, 1'b1, fr, frd, nrd, nwr, wa, wd, to);
    checks++; if (fr !== 1'b0 || frd !== 32'd0) begin
      errors++; $display("FAIL prio_first_cycle ready=%b rdata=%h exp 0 0", fr, frd); end
    checks++; if (to || nwr != 1 || nrd != 0 || wd !== 32'hCAFE_0001) begin
      errors++; $display("FAIL prio_sram wr=%0d rd=%0d data=%h exp 1 0 cafe0001", nwr, nrd, wd); end
    model_read(32'd1036, h);
    do_read(32'd1036, cyc, d, nrd, nwr, a0, a1, to);
    checks++; if (cyc != 0 || d !== 32'hCAFE_0001) begin
      errors++; $display("FAIL prio_readback got=%h cycles=%0d exp cafe0001 0", d, cyc); end
  endtask

  task automatic test_reset_abort();
    int cyc, nrd, nwr, n; logic [31:0] d, a0, a1; bit to, h, found;
    address = 32'd5632; mem_r_en = 1'b1; found = 1'b0; n = 0;
    while (!found && n < 100) begin
      @(negedge clk);
      if (sram_read_en && sram_address[2]) found = 1'b1;
      n++;
    end
    checks++; if (!found) begin errors++; $display("FAIL abort_reach_w1 got=timeout exp=second word read"); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_r_en = 1'b0;
    model_reset();
    @(negedge clk);
    checks++; if (sram_read_en !== 1'b0 || sram_write_en !== 1'b0 || ready !== 1'b1 || rdata !== 32'd0) begin
      errors++; $display("FAIL abort_idle en=%b%b ready=%b rdata=%h exp 00 1 0",
                         sram_read_en, sram_write_en, ready, rdata); end
    @(posedge clk); #1;
    model_read(32'd5632, h);
    do_read(32'd5632, cyc, d, nrd, nwr, a0, a1, to);
    checks++; if (nrd != 2 || d !== ref_mem[1408]) begin
      errors++; $display("FAIL abort_reread rd=%0d got=%h exp 2 %h", nrd, d, ref_mem[1408]); end
    model_read(32'd1032, h);
    do_read(32'd1032, cyc, d, nrd, nwr, a0, a1, to);
    checks++; if (nrd != 2 || d !== ref_mem[258]) begin
      errors++; $display("FAIL abort_old_line_invalid rd=%0d got=%h exp 2 %h", nrd, d, ref_mem[258]); end
  endtask

  task automatic test_random();
    int cyc, nrd, nwr; logic [31:0] a, d, a0, a1, frd, wa, wd, v; bit to, h, fr;
    for (int i = 0; i < 80; i++) begin
      a = 32'd1024 + 32'($urandom_range(0, 3)) * 512 + 32'($urandom_range(0, 3)) * 8
                   + 32'($urandom_range(0, 1)) * 4;
      if ($urandom_range(0, 9) < 3) begin
        v = $urandom;
        model_write(a, v, h);
        do_write(a, v, 1'b0, fr, frd, nrd, nwr, wa, wd, to);
        checks++; if (to || nwr != 1 || nrd != 0 || wa !== a || wd !== v) begin
          errors++; $display("FAIL rand_write%0d wr=%0d rd=%0d addr=%0d data=%h exp 1 0 %0d %h",
                             i, nwr, nrd, wa, wd, a, v); end
      end else begin
        model_read(a, h);
        do_read(a, cyc, d, nrd, nwr, a0, a1, to);
        checks++; if (to || nwr != 0 || (h ? (cyc != 0 || nrd != 0)
                       : (nrd != 2 || a0 !== {a[31:3], 3'b000} || a1 !== {a[31:3], 3'b100}))) begin
          errors++; $display("FAIL rand_read%0d addr=%0d cycles=%0d rd=%0d wr=%0d exp_hit=%b", i, a, cyc, nrd, nwr, h); end
        checks++; if (d !== ref_mem[a[13:2]]) begin
          errors++; $display("FAIL rand_rdata%0d addr=%0d got=%h exp=%h", i, a, d, ref_mem[a[13:2]]); end
      end
    end
    checks++; if (both_seen !== 1'b0) begin errors++; $display("FAIL enables_exclusive got=both exp=never"); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      sram_mem[i] = $urandom;
      ref_mem[i]  = sram_mem[i];
    end
    model_reset();
    test_reset();
    test_cold_read();
    test_reread();
    test_lru();
    test_write_hit();
    test_write_miss();
    test_priority();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
